opb_master_simulink2bus: RTL and testbench
==========================================

Name: opb_master_simulink2bus

Overview:
- Single-beat OPB bus master. Fabric user logic uses it to issue 32-bit reads and writes onto the OPB, toward peripherals or PPC-side memory.
- It is the initiator counterpart to the register slaves on the same bus. The slaves answer the PPC; this block lets fabric drive transactions.
- Sits between a user command/response handshake and the OPB master port of the arbiter.

Parameters:
- C_OPB_AWIDTH, 32, OPB address width (fixed 32).
- C_OPB_DWIDTH, 32, OPB data width (fixed 32).
- C_FAMILY, "virtex5", target family string (passthrough only).
- C_MAX_RETRY, 4, number of OPB_retry responses tolerated before the block reports failure.
- C_GRANT_WDOG, 64, cycles allowed waiting for OPB_MGrant before the block reports failure.

Ports:
- OPB_Clk  in  1  bus and user clock; the only clock.
- OPB_Rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_be  in  4  byte enables; bit 3 = byte lane 0 (MSB).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  read data; zero for writes.
- rsp_code  out  2  00 ok, 01 errAck, 10 bus timeout or grant watchdog, 11 retries exhausted.
- M_request  out  1  bus request.
- M_busLock  out  1  tied 0.
- M_select  out  1  master select.
- M_RNW  out  1  read/not-write.
- M_seqAddr  out  1  tied 0.
- M_BE  out  [0:3]  byte enables.
- M_ABus  out  [0:31]  address.
- M_DBus  out  [0:31]  write data.
- OPB_MGrant  in  1  grant.
- OPB_xferAck  in  1  transfer acknowledge.
- OPB_errAck  in  1  error acknowledge.
- OPB_retry  in  1  retry.
- OPB_timeout  in  1  arbiter timeout.
- OPB_DBus  in  [0:31]  read data.

Behaviour:
- All outputs are registered. On reset every output is 0 and the FSM returns to IDLE. Reset asserted mid-transfer drops M_select and M_request immediately (asynchronously). No rsp_valid is issued for the aborted command.
- Bit mapping: cmd_addr[31] maps to M_ABus[0]; the same MSB-first mapping applies to both data buses and to BE.
- M_ABus, M_DBus, M_BE and M_RNW are 0 whenever M_select = 0 (OR-bus rule). M_DBus is 0 during reads.

FSM states and transitions:
- IDLE
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch rnw/addr/wdata/be, clear the retry and watchdog counters, and move to REQ next cycle.
  - cmd_ready is 0 in every other state.
- REQ
  - M_request = 1. The watchdog increments each cycle.
  - If OPB_MGrant = 1 in a cycle: next cycle enter XFER, with M_select = 1 and M_request = 0.
  - Else, if the watchdog reaches C_GRANT_WDOG - 1: go to RESP with code 10.
- XFER
  - M_select = 1. Cycles are evaluated in this priority order:
    - OPB_errAck: code 01.
    - OPB_xferAck: code 00; on a read, capture OPB_DBus that same cycle.
    - OPB_retry: increment the retry count. If the count reaches C_MAX_RETRY, code 11 and go to RESP. Otherwise go to BACKOFF.
    - OPB_timeout: code 10.
  - Any terminating event deasserts M_select the next cycle.
- BACKOFF
  - One cycle with M_select = 0 and M_request = 0.
  - Then REQ; the watchdog is cleared again.
- RESP
  - rsp_valid = 1 for exactly one cycle, with rsp_rdata and rsp_code valid in that cycle. Next state is IDLE.

Timing and boundary rules:
- Latency with immediate grant and acknowledge:
  - command accepted at cycle 0;
  - M_request high at cycle 1;
  - M_select high at cycle 2;
  - xferAck sampled at cycle 2;
  - rsp_valid at cycle 3.
- Back-to-back: cmd_ready rises the cycle after rsp_valid, giving a minimum of 4 cycles per command.
- The retry counter is 4 bits and saturates; C_MAX_RETRY must be ≤ 15.
- errAck together with xferAck reports 01.
- A grant arriving in the same cycle the watchdog expires counts as a grant.

Decomposition:
- Shared package holds:
  - rsp_code constants: RSP_OK, RSP_ERR, RSP_TOUT, RSP_RETRY;
  - FSM state encoding;
  - the byte-swap helper for MSB-first bus mapping.
- No sub-module; a single module is natural.

Test Plan:
- Write 0x01000800 / 0xDEADBEEF / BE = F, grant and xferAck immediate:
  - M_select high for one cycle with M_ABus = 0x01000800 and M_DBus = 0xDEADBEEF;
  - rsp_valid with code 00 at cycle 3; rsp_rdata = 0.
- Read 0x01000804, slave acks after 3 wait cycles with OPB_DBus = 0x12345678:
  - rsp_rdata = 0x12345678, code 00;
  - M_DBus stays 0 throughout.
- Retry:
  - slave retries twice, then acks: two BACKOFF gaps, three select windows, code 00;
  - slave retries 4 times (C_MAX_RETRY = 4): code 11 after the fourth retry, then cmd_ready returns.
- OPB_errAck on a write: code 01. OPB_timeout asserted with no ack: code 10, M_select low the next cycle.
- Grant never arrives: rsp_valid with code 10 after 64 REQ cycles; M_request low afterwards.
- OPB_Rst pulsed while M_select = 1:
  - all outputs 0 at once, no rsp_valid;
  - cmd_ready = 1 after reset release;
  - next command completes normally.

Source files
------------

// File: rtl/opb_master_simulink2bus_pkg.sv
// Shared types, response codes and bus bit-order helpers for the OPB single-beat master.
package opb_master_simulink2bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_BACKOFF,
    ST_RESP
  } state_t;

  localparam logic [1:0] RSP_OK    = 2'b00;
  localparam logic [1:0] RSP_ERR   = 2'b01;
  localparam logic [1:0] RSP_TOUT  = 2'b10;
  localparam logic [1:0] RSP_RETRY = 2'b11;

  typedef logic [0:31] opbWord_t;
  typedef logic [0:3]  opbBe_t;

  // OPB numbers bits MSB-first: user bit 31 lands on bus bit 0.
  function automatic opbWord_t toOpbWord(input logic [31:0] v);
    opbWord_t r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [31:0] fromOpbWord(input opbWord_t v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

  function automatic opbBe_t toOpbBe(input logic [3:0] v);
    opbBe_t r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

endpackage

// File: rtl/opb_master_simulink2bus_if.sv
// User command/response handshake plus OPB master-side bus signals.
interface opb_master_simulink2bus_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rnw;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_code;

  logic        M_request;
  logic        M_busLock;
  logic        M_select;
  logic        M_RNW;
  logic        M_seqAddr;
  logic [0:3]  M_BE;
  logic [0:31] M_ABus;
  logic [0:31] M_DBus;

  logic        OPB_MGrant;
  logic        OPB_xferAck;
  logic        OPB_errAck;
  logic        OPB_retry;
  logic        OPB_timeout;
  logic [0:31] OPB_DBus;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_be,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_code,
    output M_request, M_busLock, M_select, M_RNW, M_seqAddr, M_BE, M_ABus, M_DBus,
    input  OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout, OPB_DBus
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_be,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_code,
    input  M_request, M_busLock, M_select, M_RNW, M_seqAddr, M_BE, M_ABus, M_DBus,
    output OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout, OPB_DBus
  );

endinterface

// File: rtl/opb_master_simulink2bus.sv
// Single-beat OPB bus master: turns one user command into one OPB transfer
// with retry back-off, grant watchdog and a one-cycle response strobe.
module opb_master_simulink2bus
  import opb_master_simulink2bus_pkg::*;
#(
  parameter int    C_OPB_AWIDTH = 32,
  parameter int    C_OPB_DWIDTH = 32,
  parameter string C_FAMILY     = "virtex5",
  parameter int    C_MAX_RETRY  = 4,
  parameter int    C_GRANT_WDOG = 64
) (
  input logic                        OPB_Clk,
  input logic                        OPB_Rst,
  opb_master_simulink2bus_if.master  bus
);

  localparam int         WDOG_W    = $clog2(C_GRANT_WDOG + 1);
  localparam logic [3:0] MAX_RETRY = 4'(C_MAX_RETRY);

  state_t                    r_state;
  logic [3:0]                r_retry;
  logic [WDOG_W-1:0]         r_wdog;
  logic                      r_rnw;
  logic [C_OPB_AWIDTH-1:0]   r_addr;
  logic [C_OPB_DWIDTH-1:0]   r_wdata;
  logic [3:0]                r_be;

  logic                      r_cmdReady;
  logic                      r_rspValid;
  logic [31:0]               r_rspRdata;
  logic [1:0]                r_rspCode;
  logic                      r_request;
  logic                      r_select;
  logic                      r_mRnw;
  opbBe_t                    r_mBe;
  opbWord_t                  r_mAbus;
  opbWord_t                  r_mDbus;

  state_t                    w_stateNext;
  logic [1:0]                w_codeNext;
  logic                      w_captureRead;
  logic                      w_accept;
  logic [3:0]                w_retryNext;
  logic [3:0]                w_retryInc;
  logic [WDOG_W-1:0]         w_wdogNext;

  assign w_retryInc = (r_retry == 4'hF) ? 4'hF : r_retry + 4'd1;

  // Next-state logic; the response code is only non-zero on edges into RESP.
  always_comb begin
    w_stateNext   = r_state;
    w_codeNext    = RSP_OK;
    w_captureRead = 1'b0;
    w_accept      = 1'b0;
    w_retryNext   = r_retry;
    w_wdogNext    = r_wdog;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid && r_cmdReady) begin
          w_accept    = 1'b1;
          w_retryNext = '0;
          w_wdogNext  = '0;
          w_stateNext = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.OPB_MGrant) begin
          w_stateNext = ST_XFER;
        end else if (r_wdog == WDOG_W'(C_GRANT_WDOG - 1)) begin
          w_codeNext  = RSP_TOUT;
          w_stateNext = ST_RESP;
        end else begin
          w_wdogNext = r_wdog + 1'b1;
        end
      end
      ST_XFER: begin
        if (bus.OPB_errAck) begin
          w_codeNext  = RSP_ERR;
          w_stateNext = ST_RESP;
        end else if (bus.OPB_xferAck) begin
          w_captureRead = r_rnw;
          w_stateNext   = ST_RESP;
        end else if (bus.OPB_retry) begin
          w_retryNext = w_retryInc;
          if (w_retryInc >= MAX_RETRY) begin
            w_codeNext  = RSP_RETRY;
            w_stateNext = ST_RESP;
          end else begin
            w_stateNext = ST_BACKOFF;
          end
        end else if (bus.OPB_timeout) begin
          w_codeNext  = RSP_TOUT;
          w_stateNext = ST_RESP;
        end
      end
      ST_BACKOFF: begin
        w_wdogNext  = '0;
        w_stateNext = ST_REQ;
      end
      ST_RESP:  w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_state    <= ST_IDLE;
      r_retry    <= '0;
      r_wdog     <= '0;
      r_rnw      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_cmdReady <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspCode  <= RSP_OK;
      r_request  <= 1'b0;
      r_select   <= 1'b0;
      r_mRnw     <= 1'b0;
      r_mBe      <= '0;
      r_mAbus    <= '0;
      r_mDbus    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_retry    <= w_retryNext;
      r_wdog     <= w_wdogNext;
      if (w_accept) begin
        r_rnw   <= bus.cmd_rnw;
        r_addr  <= bus.cmd_addr;
        r_wdata <= bus.cmd_wdata;
        r_be    <= bus.cmd_be;
      end
      r_cmdReady <= (w_stateNext == ST_IDLE);
      r_request  <= (w_stateNext == ST_REQ);
      r_select   <= (w_stateNext == ST_XFER);
      r_rspValid <= (w_stateNext == ST_RESP);
      r_rspCode  <= w_codeNext;
      r_rspRdata <= w_captureRead ? fromOpbWord(bus.OPB_DBus) : '0;
      if (w_stateNext == ST_XFER) begin
        r_mRnw  <= r_rnw;
        r_mBe   <= toOpbBe(r_be);
        r_mAbus <= toOpbWord(r_addr);
        r_mDbus <= r_rnw ? '0 : toOpbWord(r_wdata);
      end else begin
        r_mRnw  <= 1'b0;
        r_mBe   <= '0;
        r_mAbus <= '0;
        r_mDbus <= '0;
      end
    end
  end

  assign bus.cmd_ready = r_cmdReady;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_rdata = r_rspRdata;
  assign bus.rsp_code  = r_rspCode;
  assign bus.M_request = r_request;
  assign bus.M_busLock = 1'b0;
  assign bus.M_select  = r_select;
  assign bus.M_RNW     = r_mRnw;
  assign bus.M_seqAddr = 1'b0;
  assign bus.M_BE      = r_mBe;
  assign bus.M_ABus    = r_mAbus;
  assign bus.M_DBus    = r_mDbus;

endmodule

// File: tb/tb_opb_master_simulink2bus.sv
// Directed bench for the OPB master: a scripted OPB slave/arbiter plus a response scoreboard.
module tb_opb_master_simulink2bus;
  import opb_master_simulink2bus_pkg::*;

  localparam int EV_ACK  = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_TOUT = 2;
  localparam int EV_BOTH = 3;
  localparam int NEVER   = 100000;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  code;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  opb_master_simulink2bus_if bus();

  opb_master_simulink2bus #(
    .C_MAX_RETRY (4),
    .C_GRANT_WDOG(64)
  ) dut (
    .OPB_Clk(clk),
    .OPB_Rst(rst),
    .bus    (bus)
  );

  rsp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   rspSeen = 0;
  int   unexpected = 0;
  int   sFirstReq, sFirstSel, sRspStep, sWindows, sGaps, sReqCycles;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response strobe pops the oldest expectation.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rst === 1'b0 && bus.rsp_valid === 1'b1) begin
      rspSeen++;
      if (expQ.size() == 0) begin
        unexpected++;
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_code", 32'(bus.rsp_code), 32'(e.code));
        checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
      end
    end
  end

  task automatic applyStimulus(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] expRdata,
                               input logic [1:0] expCode, input bit expectRsp);
    rsp_t e;
    int   n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checkOutput("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rnw   = rnw;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_be    = be;
    if (expectRsp) begin
      e.rdata = expRdata;
      e.code  = expCode;
      expQ.push_back(e);
    end
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_rnw   = 1'b0;
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    bus.cmd_be    = 4'h0;
  endtask

  // Plays arbiter and slave until the response strobe, checking the bus every cycle.
  task automatic serve(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int grantDelay, input int retries,
                       input int waits, input int finalEv, input logic [31:0] rdata);
    int stepIdx = 1;
    int phaseReq = 0;
    int selCyc = 0;
    int retriesDone = 0;
    bit prevSel = 1'b0;
    bit done = 1'b0;
    sFirstReq = 0; sFirstSel = 0; sRspStep = 0; sWindows = 0; sGaps = 0; sReqCycles = 0;
    while (!done && stepIdx < 300) begin
      bus.OPB_MGrant  = 1'b0;
      bus.OPB_xferAck = 1'b0;
      bus.OPB_errAck  = 1'b0;
      bus.OPB_retry   = 1'b0;
      bus.OPB_timeout = 1'b0;
      bus.OPB_DBus    = '0;
      if (bus.M_select === 1'b1) begin
        checkOutput("m_abus", bus.M_ABus, addr);
        checkOutput("m_dbus", bus.M_DBus, rnw ? 32'h0 : wdata);
        checkOutput("m_be", 32'(bus.M_BE), 32'(be));
        checkOutput("m_rnw", 32'(bus.M_RNW), 32'(rnw));
      end else begin
        checkOutput("orbus_idle", bus.M_ABus | bus.M_DBus | 32'(bus.M_BE) | 32'(bus.M_RNW), 32'h0);
      end
      if (bus.rsp_valid === 1'b1) begin
        sRspStep = stepIdx;
        done = 1'b1;
        checkOutput("sel_low_at_rsp", 32'(bus.M_select), 32'd0);
        checkOutput("req_low_at_rsp", 32'(bus.M_request), 32'd0);
      end else if (bus.M_request === 1'b1) begin
        sReqCycles++;
        phaseReq++;
        if (sFirstReq == 0) sFirstReq = stepIdx;
        if (phaseReq > grantDelay) bus.OPB_MGrant = 1'b1;
      end else if (bus.M_select === 1'b1) begin
        if (!prevSel) begin
          sWindows++;
          selCyc = 0;
        end
        if (sFirstSel == 0) sFirstSel = stepIdx;
        if (selCyc < waits) begin
          selCyc++;
        end else if (retriesDone < retries) begin
          bus.OPB_retry = 1'b1;
          retriesDone++;
        end else begin
          case (finalEv)
            EV_ACK:  begin bus.OPB_xferAck = 1'b1; bus.OPB_DBus = rdata; end
            EV_ERR:  bus.OPB_errAck = 1'b1;
            EV_TOUT: bus.OPB_timeout = 1'b1;
            default: begin bus.OPB_errAck = 1'b1; bus.OPB_xferAck = 1'b1; bus.OPB_DBus = rdata; end
          endcase
        end
      end else begin
        phaseReq = 0;
        if (sWindows > 0) sGaps++;
      end
      prevSel = bus.M_select;
      step();
      stepIdx++;
    end
    bus.OPB_MGrant  = 1'b0;
    bus.OPB_xferAck = 1'b0;
    bus.OPB_errAck  = 1'b0;
    bus.OPB_retry   = 1'b0;
    bus.OPB_timeout = 1'b0;
    bus.OPB_DBus    = '0;
    checkOutput("serve_done", 32'(done), 32'd1);
  endtask

  initial begin : stimulus
    int rspBefore;
    int n;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_rnw = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_be = '0;
    bus.OPB_MGrant = 1'b0; bus.OPB_xferAck = 1'b0; bus.OPB_errAck = 1'b0;
    bus.OPB_retry = 1'b0; bus.OPB_timeout = 1'b0; bus.OPB_DBus = '0;
    step();
    step();

    $display("[TB] reset state");
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_request", 32'(bus.M_request), 32'd0);
    checkOutput("rst_select", 32'(bus.M_select), 32'd0);
    checkOutput("rst_ties", 32'({bus.M_busLock, bus.M_seqAddr}), 32'd0);
    checkOutput("rst_abus", bus.M_ABus, 32'h0);
    rst = 1'b0;
    step();
    checkOutput("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] write, immediate grant and ack");
    applyStimulus(1'b0, 32'h0100_0800, 32'hDEAD_BEEF, 4'hF, 32'h0, RSP_OK, 1'b1);
    serve(1'b0, 32'h0100_0800, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, EV_ACK, 32'h0);
    checkOutput("lat_request", sFirstReq, 1);
    checkOutput("lat_select", sFirstSel, 2);
    checkOutput("lat_rsp", sRspStep, 3);
    checkOutput("wr_windows", sWindows, 1);
    checkOutput("b2b_ready", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] read with 3 wait states");
    applyStimulus(1'b1, 32'h0100_0804, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, RSP_OK, 1'b1);
    serve(1'b1, 32'h0100_0804, 32'hFFFF_FFFF, 4'hF, 0, 0, 3, EV_ACK, 32'h1234_5678);
    checkOutput("rd_rsp_step", sRspStep, 6);

    $display("[TB] two retries then ack");
    applyStimulus(1'b0, 32'h0000_0010, 32'hA5A5_0001, 4'hC, 32'h0, RSP_OK, 1'b1);
    serve(1'b0, 32'h0000_0010, 32'hA5A5_0001, 4'hC, 0, 2, 0, EV_ACK, 32'h0);
    checkOutput("retry2_windows", sWindows, 3);
    checkOutput("retry2_gaps", sGaps, 2);

    $display("[TB] retries exhausted");
    applyStimulus(1'b1, 32'h0000_0020, 32'h0, 4'h3, 32'h0, RSP_RETRY, 1'b1);
    serve(1'b1, 32'h0000_0020, 32'h0, 4'h3, 0, 4, 0, EV_ACK, 32'h5555_5555);
    checkOutput("retry4_windows", sWindows, 4);
    checkOutput("retry4_gaps", sGaps, 3);
    checkOutput("retry4_ready", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] errAck on write");
    applyStimulus(1'b0, 32'h4000_0000, 32'h0BAD_F00D, 4'h8, 32'h0, RSP_ERR, 1'b1);
    serve(1'b0, 32'h4000_0000, 32'h0BAD_F00D, 4'h8, 2, 0, 1, EV_ERR, 32'h0);

    $display("[TB] bus timeout on read");
    applyStimulus(1'b1, 32'h4000_0004, 32'h0, 4'hF, 32'h0, RSP_TOUT, 1'b1);
    serve(1'b1, 32'h4000_0004, 32'h0, 4'hF, 0, 0, 2, EV_TOUT, 32'hFFFF_FFFF);

    $display("[TB] grant watchdog");
    applyStimulus(1'b0, 32'h8000_0000, 32'h1111_2222, 4'hF, 32'h0, RSP_TOUT, 1'b1);
    serve(1'b0, 32'h8000_0000, 32'h1111_2222, 4'hF, NEVER, 0, 0, EV_ACK, 32'h0);
    checkOutput("wdog_req_cycles", sReqCycles, 64);
    checkOutput("wdog_windows", sWindows, 0);
    checkOutput("wdog_req_after", 32'(bus.M_request), 32'd0);

    $display("[TB] grant in the watchdog expiry cycle");
    applyStimulus(1'b0, 32'h8000_0040, 32'h3333_4444, 4'hF, 32'h0, RSP_OK, 1'b1);
    serve(1'b0, 32'h8000_0040, 32'h3333_4444, 4'hF, 63, 0, 0, EV_ACK, 32'h0);
    checkOutput("late_grant_req_cycles", sReqCycles, 64);
    checkOutput("late_grant_windows", sWindows, 1);

    $display("[TB] errAck with xferAck on read");
    applyStimulus(1'b1, 32'h0000_0100, 32'h0, 4'hF, 32'h0, RSP_ERR, 1'b1);
    serve(1'b1, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 0, EV_BOTH, 32'h7777_8888);

    $display("[TB] reset during select");
    applyStimulus(1'b0, 32'h0000_0200, 32'h9999_AAAA, 4'hF, 32'h0, RSP_OK, 1'b0);
    n = 0;
    while (bus.M_select !== 1'b1 && n < 10) begin
      bus.OPB_MGrant = bus.M_request;
      step();
      n++;
    end
    bus.OPB_MGrant = 1'b0;
    checkOutput("abort_select_seen", 32'(bus.M_select), 32'd1);
    rspBefore = rspSeen;
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_select", 32'(bus.M_select), 32'd0);
    checkOutput("abort_request", 32'(bus.M_request), 32'd0);
    checkOutput("abort_bus", bus.M_ABus | bus.M_DBus | 32'(bus.M_BE), 32'h0);
    checkOutput("abort_ready", 32'(bus.cmd_ready), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    checkOutput("abort_ready_after", 32'(bus.cmd_ready), 32'd1);
    step();
    checkOutput("abort_no_rsp", rspSeen, rspBefore);

    $display("[TB] read after abort");
    applyStimulus(1'b1, 32'h0000_0300, 32'h0, 4'hF, 32'hCAFE_F00D, RSP_OK, 1'b1);
    serve(1'b1, 32'h0000_0300, 32'h0, 4'hF, 0, 0, 0, EV_ACK, 32'hCAFE_F00D);
    checkOutput("post_lat_rsp", sRspStep, 3);

    step();
    step();
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    checkOutput("unexpected_rsp", unexpected, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
